// File: rtl/issue_scoreboard.sv
// issue_scoreboard: decode-stage hazard controller built on per-register writeback countdowns.
// Define ASCA_FWD_EN for bypass-aware hazard checks and the fwd_a/fwd_b outputs.

module sb_cnt_cell #(
    parameter int CNT_W  = 3,
    parameter int WB_LAT = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hold,
    input  logic             load,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt
);
    // A load always wins over the decrement; load is only raised when not held.
    always_comb begin
        cnt_nxt = cnt;
        if (!hold) begin
            if (load)
                cnt_nxt = CNT_W'(WB_LAT);
            else if (cnt != '0)
                cnt_nxt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end
endmodule

module issue_scoreboard #(
    parameter int WB_LAT   = 3,
    parameter int CNT_W    = 3,
    parameter int OPCODE_W = 4,
    parameter int REG_N    = 4,
    parameter logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(1),
    parameter logic [OPCODE_W-1:0] OP_LDRH = OPCODE_W'(2),
    parameter logic [OPCODE_W-1:0] OP_LDRL = OPCODE_W'(3),
    parameter logic [OPCODE_W-1:0] OP_LSR  = OPCODE_W'(4),
    parameter logic [OPCODE_W-1:0] OP_LSL  = OPCODE_W'(5),
    parameter logic [OPCODE_W-1:0] OP_ASR  = OPCODE_W'(6)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_N-1:0]    id_nrega,
    input  logic [REG_N-1:0]    id_nregb,
    input  logic                id_usea,
    input  logic                id_useb,
    input  logic                id_wr,
    input  logic                mem_busy,
    output logic                stall,
    output logic                issue,
`ifdef ASCA_FWD_EN
    output logic                fwd_a,
    output logic                fwd_b,
`endif
    output logic [15:0]         busy_mask,
    output logic [15:0]         stall_cnt
);
    localparam int NREG = 2 ** REG_N;

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0][CNT_W-1:0] cnt_nxt;
    logic                       narrow_a;
    logic [REG_N-1:0]           eff_a;
    logic [CNT_W-1:0]           cnt_a;
    logic [CNT_W-1:0]           cnt_b;
    logic                       haz_a;
    logic                       haz_b;

    // Immediate/shift forms encode an extra bit in nrega, so only the upper bits name A.
    assign narrow_a = id_opcode inside {OP_ADDI, OP_LDRH, OP_LDRL, OP_LSR, OP_LSL, OP_ASR};
    assign eff_a    = narrow_a ? {1'b0, id_nrega[REG_N-1:1]} : id_nrega;
    assign cnt_a    = cnt[eff_a];
    assign cnt_b    = cnt[id_nregb];

`ifdef ASCA_FWD_EN
    // A count of 1 means the value is on the bypass path next cycle.
    assign haz_a = id_usea && (cnt_a > CNT_W'(1));
    assign haz_b = id_useb && (cnt_b > CNT_W'(1));
    assign fwd_a = id_usea && (cnt_a == CNT_W'(1));
    assign fwd_b = id_useb && (cnt_b == CNT_W'(1));
`else
    assign haz_a = id_usea && (cnt_a != '0);
    assign haz_b = id_useb && (cnt_b != '0);
`endif

    assign stall = id_valid && (haz_a || haz_b || mem_busy);
    assign issue = id_valid && !stall;

    for (genvar i = 0; i < NREG; i++) begin : g_cell
        sb_cnt_cell #(.CNT_W(CNT_W), .WB_LAT(WB_LAT)) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .hold    (mem_busy),
            .load    (issue && id_wr && (eff_a == REG_N'(i))),
            .cnt     (cnt[i]),
            .cnt_nxt (cnt_nxt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_mask <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                busy_mask[i] <= |cnt_nxt[i];
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule
